// File: rtl/alu_pipelined.sv
// In-order ALU with a command FIFO in front of a single execution unit.
// One-cycle ops stream back to back; MUL holds the unit for MUL_LATENCY cycles.
module alu_pipelined #(
   parameter int DATA_WIDTH  = 8,
   parameter int FIFO_DEPTH  = 4,
   parameter int MUL_LATENCY = 3
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 alu_rst,
   input  logic                                 valid,
   output logic                                 ready,
   input  logic [2:0]                           op,
   input  logic [DATA_WIDTH-1:0]                a,
   input  logic [DATA_WIDTH-1:0]                b,
   output logic                                 done,
   output logic [2*DATA_WIDTH-1:0]              result,
   output logic                                 busy,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]      count
);

   localparam int RW = 2 * DATA_WIDTH;
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int LW = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;

   localparam logic [2:0] OP_ADD = 3'd1;
   localparam logic [2:0] OP_AND = 3'd2;
   localparam logic [2:0] OP_XOR = 3'd3;
   localparam logic [2:0] OP_MUL = 3'd4;
   localparam logic [2:0] OP_SUB = 3'd5;

   typedef enum logic {IDLE, EXEC} state_t;

   state_t                state, next_state;
   logic [2:0]            fifo_op [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] fifo_a  [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] fifo_b  [FIFO_DEPTH];
   logic [PW-1:0]         wptr, rptr;
   logic                  full, push, pop, complete;
   logic [LW-1:0]         cnt, head_lat;
   logic [2:0]            op_reg;
   logic [DATA_WIDTH-1:0] a_reg, b_reg;
   logic [RW-1:0]         a_ext, b_ext, exec_result;
   logic                  op_reports;

   assign full  = (count == CW'(FIFO_DEPTH));
   assign ready = rst && !alu_rst && !full;
   assign push  = valid && ready;
   assign busy  = (state == EXEC);

   // Pops happen from IDLE or on the completing edge of EXEC, so the unit never idles a cycle between ops.
   always_comb begin
      next_state = state;
      pop        = 1'b0;
      complete   = 1'b0;
      case (state)
         IDLE: begin
            if (count != '0) begin
               pop        = 1'b1;
               next_state = EXEC;
            end
         end
         EXEC: begin
            if (cnt == '0) begin
               complete = 1'b1;
               if (count != '0) pop = 1'b1;
               else             next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
      if (alu_rst) begin
         next_state = IDLE;
         pop        = 1'b0;
         complete   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) state <= IDLE;
      else      state <= next_state;
   end

   // Payload storage needs no reset; only the pointers and occupancy define what is valid.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_op[wptr] <= op;
         fifo_a[wptr]  <= a;
         fifo_b[wptr]  <= b;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst || alu_rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push) wptr <= wptr + PW'(1);
         if (pop)  rptr <= rptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   assign head_lat = (fifo_op[rptr] == OP_MUL) ? LW'(MUL_LATENCY - 1) : '0;
   assign a_ext    = RW'(a_reg);
   assign b_ext    = RW'(b_reg);
   assign op_reports = (op_reg >= OP_ADD) && (op_reg <= OP_SUB);

   always_comb begin
      exec_result = '0;
      case (op_reg)
         OP_ADD:  exec_result = a_ext + b_ext;
         OP_AND:  exec_result = a_ext & b_ext;
         OP_XOR:  exec_result = a_ext ^ b_ext;
         OP_MUL:  exec_result = a_ext * b_ext;
         OP_SUB:  exec_result = a_ext - b_ext;
         default: exec_result = '0;
      endcase
   end

   // A completing op and the next op's load share an edge; the result uses the outgoing operands.
   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt    <= '0;
         op_reg <= '0;
         a_reg  <= '0;
         b_reg  <= '0;
         done   <= 1'b0;
         result <= '0;
      end else if (alu_rst) begin
         cnt  <= '0;
         done <= 1'b0;
      end else begin
         done <= 1'b0;
         if (complete && op_reports) begin
            result <= exec_result;
            done   <= 1'b1;
         end
         if (pop) begin
            op_reg <= fifo_op[rptr];
            a_reg  <= fifo_a[rptr];
            b_reg  <= fifo_b[rptr];
            cnt    <= head_lat;
         end else if (state == EXEC && cnt != '0) begin
            cnt <= cnt - LW'(1);
         end
      end
   end

endmodule

// File: tb/tb_alu_pipelined.sv
// Bench for alu_pipelined: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed results and timing.
module tb_alu_pipelined;

   localparam int DW    = 8;
   localparam int DEPTH = 4;
   localparam int ML    = 3;
   localparam int CW    = $clog2(DEPTH + 1);

   typedef struct {
      logic [2:0]    op;
      logic [DW-1:0] a;
      logic [DW-1:0] b;
   } cmd_t;

   logic            clk = 1'b0;
   logic            rst, alu_rst, valid;
   logic            ready, done, busy;
   logic [2:0]      op;
   logic [DW-1:0]   a, b;
   logic [2*DW-1:0] result;
   logic [CW-1:0]   count;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   bit check_en = 0;
   bit saw_full = 0;
   int acc_cyc;

   cmd_t            q[$];
   bit              m_busy;
   cmd_t            m_cur;
   int              m_rem;
   logic [15:0]     m_result;
   bit              m_done;
   logic [15:0]     got_res[$];
   int              got_cyc[$];

   alu_pipelined #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .MUL_LATENCY(ML)) dut (
      .clk(clk), .rst(rst), .alu_rst(alu_rst), .valid(valid), .ready(ready),
      .op(op), .a(a), .b(b), .done(done), .result(result), .busy(busy), .count(count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   function automatic logic [15:0] modelOp(cmd_t c);
      int x, y;
      x = int'(c.a);
      y = int'(c.b);
      case (c.op)
         3'd1:    return 16'(x + y);
         3'd2:    return 16'(x & y);
         3'd3:    return 16'(x ^ y);
         3'd4:    return 16'(x * y);
         3'd5:    return 16'(x - y + 65536);
         default: return 16'h0;
      endcase
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   // Reference model: a command queue plus one in-flight op with a remaining-cycle counter.
   always @(posedge clk) begin
      bit acc;
      acc = valid && rst && !alu_rst && (q.size() < DEPTH);
      if (!rst) begin
         q.delete();
         m_busy = 0; m_rem = 0; m_result = 16'h0; m_done = 0;
      end else if (alu_rst) begin
         q.delete();
         m_busy = 0; m_rem = 0; m_done = 0;
      end else begin
         bit start;
         m_done = 0;
         start  = 0;
         if (m_busy) begin
            if (m_rem > 0) m_rem--;
            else begin
               if (m_cur.op >= 3'd1 && m_cur.op <= 3'd5) begin
                  m_result = modelOp(m_cur);
                  m_done   = 1;
               end
               m_busy = 0;
               start  = (q.size() > 0);
            end
         end else begin
            start = (q.size() > 0);
         end
         if (start) begin
            m_cur  = q.pop_front();
            m_busy = 1;
            m_rem  = (m_cur.op == 3'd4) ? ML - 1 : 0;
         end
         if (acc) q.push_back('{op, a, b});
      end
   end

   always @(posedge clk) begin
      #2;
      if (check_en) begin
         checkOutput("ready",  32'(ready),  32'(rst && !alu_rst && (q.size() < DEPTH)));
         checkOutput("done",   32'(done),   32'(m_done));
         checkOutput("result", 32'(result), 32'(m_result));
         checkOutput("busy",   32'(busy),   32'(m_busy));
         checkOutput("count",  32'(count),  32'(q.size()));
         if (done === 1'b1) begin
            got_res.push_back(result);
            got_cyc.push_back(cyc);
         end
      end
   end

   task automatic applyStimulus(input logic [2:0] o, input logic [DW-1:0] x, input logic [DW-1:0] y);
      bit acc;
      acc = 0;
      for (int i = 0; i < 50 && !acc; i++) begin
         @(negedge clk);
         valid = 1'b1; op = o; a = x; b = y;
         #1;
         acc = ready;
         if (!ready && count == CW'(DEPTH)) saw_full = 1;
         @(posedge clk);
         #1;
         acc_cyc = cyc;
      end
      if (!acc) checkOutput("accept_timeout", 32'(acc), 32'd1);
   endtask

   task automatic idleCycles(input int n);
      @(negedge clk);
      valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic waitResults(input int n, input int budget);
      for (int i = 0; i < budget && got_res.size() < n; i++) @(posedge clk);
      #3;
      checkOutput("wait_results", 32'(got_res.size()), 32'(n));
   endtask

   task automatic clearLog();
      got_res.delete();
      got_cyc.delete();
   endtask

   initial begin
      int n_edge;
      rst = 1'b0; alu_rst = 1'b0; valid = 1'b1; op = 3'd1; a = 8'hFF; b = 8'h01;

      // Reset held with a command offered: nothing may be enqueued.
      @(posedge clk);
      #1 check_en = 1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_ready",  32'(ready),  32'd0);
      checkOutput("rst_done",   32'(done),   32'd0);
      checkOutput("rst_result", 32'(result), 32'd0);
      checkOutput("rst_count",  32'(count),  32'd0);
      rst = 1'b1; valid = 1'b0;
      @(negedge clk);
      checkOutput("post_rst_count", 32'(count), 32'd0);
      checkOutput("post_rst_busy",  32'(busy),  32'd0);

      // Single ADD: done appears two edges after acceptance.
      clearLog();
      applyStimulus(3'd1, 8'hFF, 8'h01);
      n_edge = acc_cyc;
      idleCycles(1);
      waitResults(1, 20);
      if (got_res.size() >= 1) begin
         checkOutput("add_result",  32'(got_res[0]), 32'h0100);
         checkOutput("add_latency", 32'(got_cyc[0] - n_edge), 32'd2);
      end
      idleCycles(3);

      // Mixed stream on consecutive cycles.
      clearLog();
      applyStimulus(3'd1, 8'd3, 8'd5);
      applyStimulus(3'd4, 8'd16, 8'd16);
      applyStimulus(3'd5, 8'd3, 8'd5);
      applyStimulus(3'd3, 8'hF0, 8'h0F);
      idleCycles(1);
      waitResults(4, 40);
      if (got_res.size() >= 4) begin
         checkOutput("mix_add", 32'(got_res[0]), 32'd8);
         checkOutput("mix_mul", 32'(got_res[1]), 32'd256);
         checkOutput("mix_sub", 32'(got_res[2]), 32'hFFFE);
         checkOutput("mix_xor", 32'(got_res[3]), 32'h00FF);
         checkOutput("mix_mul_gap", 32'(got_cyc[1] - got_cyc[0]), 32'd3);
         checkOutput("mix_tail_gap", 32'(got_cyc[3] - got_cyc[1]), 32'd2);
      end
      idleCycles(3);

      // Backpressure: six MULs offered continuously into a four-entry queue.
      clearLog();
      saw_full = 0;
      for (int i = 0; i < 6; i++) applyStimulus(3'd4, 8'(i + 1), 8'(i + 2));
      @(negedge clk);
      if (!ready && count == CW'(DEPTH)) saw_full = 1;
      idleCycles(1);
      checkOutput("bp_full_seen", 32'(saw_full), 32'd1);
      waitResults(6, 100);
      if (got_res.size() >= 6) begin
         checkOutput("bp_r0", 32'(got_res[0]), 32'd2);
         checkOutput("bp_r1", 32'(got_res[1]), 32'd6);
         checkOutput("bp_r2", 32'(got_res[2]), 32'd12);
         checkOutput("bp_r3", 32'(got_res[3]), 32'd20);
         checkOutput("bp_r4", 32'(got_res[4]), 32'd30);
         checkOutput("bp_r5", 32'(got_res[5]), 32'd42);
      end
      idleCycles(5);
      checkOutput("bp_no_extra", 32'(got_res.size()), 32'd6);

      // Flush while a MUL executes with two ADDs queued behind it.
      clearLog();
      applyStimulus(3'd4, 8'd7, 8'd9);
      applyStimulus(3'd1, 8'd1, 8'd2);
      applyStimulus(3'd1, 8'd3, 8'd4);
      @(negedge clk);
      valid = 1'b0;
      checkOutput("flush_pre_count", 32'(count), 32'd2);
      checkOutput("flush_pre_busy",  32'(busy),  32'd1);
      alu_rst = 1'b1;
      @(negedge clk);
      alu_rst = 1'b0;
      checkOutput("flush_count",  32'(count),  32'd0);
      checkOutput("flush_busy",   32'(busy),   32'd0);
      checkOutput("flush_result", 32'(result), 32'd42);
      repeat (8) @(negedge clk);
      checkOutput("flush_no_done", 32'(got_res.size()), 32'd0);
      applyStimulus(3'd1, 8'd1, 8'd1);
      idleCycles(1);
      waitResults(1, 20);
      if (got_res.size() >= 1) checkOutput("flush_then_add", 32'(got_res[0]), 32'd2);
      idleCycles(3);

      // NO_OP and reserved op between two ANDs: each adds one cycle of spacing.
      clearLog();
      applyStimulus(3'd2, 8'hF0, 8'h3C);
      applyStimulus(3'd0, 8'h11, 8'h22);
      applyStimulus(3'd7, 8'h33, 8'h44);
      applyStimulus(3'd2, 8'hFF, 8'h0F);
      idleCycles(1);
      waitResults(2, 30);
      idleCycles(4);
      checkOutput("nop_pulses", 32'(got_res.size()), 32'd2);
      if (got_res.size() >= 2) begin
         checkOutput("nop_and0", 32'(got_res[0]), 32'h0030);
         checkOutput("nop_and1", 32'(got_res[1]), 32'h000F);
         checkOutput("nop_gap",  32'(got_cyc[1] - got_cyc[0]), 32'd3);
      end

      check_en = 0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
